// File: rtl/mips_cpu_bus_arbiter_if.sv
// Avalon-style bus bundle shared by the CPU fetch port, CPU data port and the memory slave.
// The master modport issues commands; the slave modport answers with waitrequest/readdata/error.
interface mips_cpu_bus_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic              waitrequest;
  logic [31:0]       readdata;
  logic              error;

  modport master (
    output read, write, address, byteenable, writedata,
    input  waitrequest, readdata, error
  );

  modport slave (
    input  read, write, address, byteenable, writedata,
    output waitrequest, readdata, error
  );
endinterface

// File: rtl/mips_cpu_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style memory bus between the CPU fetch and data ports.
// One transaction in flight; read data is captured READ_LATENCY cycles after the slave accepts.
module mips_cpu_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  mips_cpu_bus_arbiter_if.slave  ibus,
  mips_cpu_bus_arbiter_if.slave  dbus,
  mips_cpu_bus_arbiter_if.master sbus
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RD  = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  state_t            state;
  state_t            state_nxt;
  port_t             owner;
  port_t             last;
  port_t             grant;
  logic              req_i;
  logic              req_d;
  logic              grant_valid;
  logic              d_conflict;
  logic              err_grant;
  logic              issuing;
  logic              accepted;
  logic              last_beat;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] cmd_addr;
  logic [3:0]        cmd_be;
  logic [31:0]       cmd_wdata;
  logic              cmd_write;
  logic [31:0]       rdata_q;
  logic [31:0]       i_rdata_q;
  logic [31:0]       d_rdata_q;
  logic              unused_inputs;

  // Fetch port is read-only and the slave never reports errors, so these inputs are ignored.
  assign unused_inputs = ^{ibus.write, ibus.byteenable, ibus.writedata, sbus.error};

  // With both ports requesting, the one not served last wins, bounding the wait to one transaction.
  always_comb begin
    req_i       = ibus.read;
    req_d       = dbus.read | dbus.write;
    grant_valid = req_i | req_d;
    d_conflict  = dbus.read & dbus.write;
    grant       = PORT_I;
    if (req_i && req_d) begin
      grant = (last == PORT_I) ? PORT_D : PORT_I;
    end else if (req_d) begin
      grant = PORT_D;
    end
    err_grant = (state == IDLE) && grant_valid && (grant == PORT_D) && d_conflict;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issuing   = (state == ISSUE);
    accepted  = issuing && !sbus.waitrequest;
    last_beat = (state == WAIT_RD) && (cnt == '0);

    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_nxt = err_grant ? COMPLETE : ISSUE;
        end
      end
      ISSUE: begin
        if (accepted) begin
          state_nxt = cmd_write ? COMPLETE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (last_beat) begin
          state_nxt = COMPLETE;
        end
      end
      COMPLETE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase

    sbus.read        = issuing & ~cmd_write;
    sbus.write       = issuing & cmd_write;
    sbus.address     = issuing ? cmd_addr : '0;
    sbus.byteenable  = issuing ? cmd_be : 4'b0000;
    sbus.writedata   = issuing ? cmd_wdata : 32'h0;

    ibus.waitrequest = !((state == COMPLETE) && (owner == PORT_I));
    dbus.waitrequest = !((state == COMPLETE) && (owner == PORT_D));
    ibus.readdata    = i_rdata_q;
    dbus.readdata    = d_rdata_q;
    ibus.error       = 1'b0;
    // Gated so the Mealy error output stays quiet while reset holds the FSM in IDLE.
    dbus.error       = err_grant & reset_n;
  end

  // Each port's readdata view is loaded only as that port enters COMPLETE, then held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner     <= PORT_I;
      last      <= PORT_D;
      cnt       <= '0;
      cmd_addr  <= '0;
      cmd_be    <= 4'b0000;
      cmd_wdata <= 32'h0;
      cmd_write <= 1'b0;
      rdata_q   <= 32'h0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner <= grant;
            last  <= grant;
            if (grant == PORT_I) begin
              cmd_addr  <= ibus.address;
              cmd_be    <= 4'b1111;
              cmd_wdata <= 32'h0;
              cmd_write <= 1'b0;
            end else begin
              cmd_addr  <= dbus.address;
              cmd_be    <= dbus.byteenable;
              cmd_wdata <= dbus.writedata;
              cmd_write <= dbus.write;
            end
            if (err_grant) begin
              rdata_q   <= 32'h0;
              d_rdata_q <= 32'h0;
            end
          end
        end
        ISSUE: begin
          if (accepted) begin
            if (!cmd_write) begin
              cnt <= CNT_LOAD;
            end else if (owner == PORT_I) begin
              i_rdata_q <= rdata_q;
            end else begin
              d_rdata_q <= rdata_q;
            end
          end
        end
        WAIT_RD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rdata_q <= sbus.readdata;
            if (owner == PORT_I) begin
              i_rdata_q <= sbus.readdata;
            end else begin
              d_rdata_q <= sbus.readdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Bench for mips_cpu_bus_arbiter: a transaction-level model expands each grant into its expected
// cycle sequence and is compared every cycle; directed tests pin latencies, ordering and reset.
module tb_mips_cpu_bus_arbiter;

  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mips_cpu_bus_arbiter_if #(.ADDR_W(ADDR_W)) ibus ();
  mips_cpu_bus_arbiter_if #(.ADDR_W(ADDR_W)) dbus ();
  mips_cpu_bus_arbiter_if #(.ADDR_W(ADDR_W)) sbus ();
  mips_cpu_bus_arbiter_if #(.ADDR_W(ADDR_W)) ibus3 ();
  mips_cpu_bus_arbiter_if #(.ADDR_W(ADDR_W)) dbus3 ();
  mips_cpu_bus_arbiter_if #(.ADDR_W(ADDR_W)) sbus3 ();

  mips_cpu_bus_arbiter #(.ADDR_W(ADDR_W), .READ_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .ibus(ibus), .dbus(dbus), .sbus(sbus)
  );

  mips_cpu_bus_arbiter #(.ADDR_W(ADDR_W), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .ibus(ibus3), .dbus(dbus3), .sbus(sbus3)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0BFC_0000) return 32'h8C01_0004;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Slave for the latency-1 DUT: stalls the first stall_cfg cycles of each command.
  int unsigned stall_cfg = 0;
  int unsigned stall_seen = 0;
  logic        pipe_v = 1'b0;
  logic [31:0] pipe_d = 32'h0;

  assign ibus.write       = 1'b0;
  assign ibus.byteenable  = 4'b0000;
  assign ibus.writedata   = 32'h0;
  assign sbus.waitrequest = (stall_seen < stall_cfg);
  assign sbus.readdata    = pipe_v ? pipe_d : 32'hBAD0_BAD0;
  assign sbus.error       = 1'b0;

  always @(posedge clk) begin
    stall_seen <= ((sbus.read || sbus.write) && sbus.waitrequest) ? stall_seen + 1 : 0;
    pipe_v     <= sbus.read & ~sbus.waitrequest;
    pipe_d     <= mem_word(sbus.address);
  end

  // Slave for the latency-3 DUT: never stalls.
  logic [2:0]  pipe3_v = 3'b000;
  logic [31:0] pipe3_d [3];

  assign ibus3.write       = 1'b0;
  assign ibus3.byteenable  = 4'b0000;
  assign ibus3.writedata   = 32'h0;
  assign ibus3.read        = 1'b0;
  assign ibus3.address     = '0;
  assign sbus3.waitrequest = 1'b0;
  assign sbus3.readdata    = pipe3_v[2] ? pipe3_d[2] : 32'hBAD0_BAD0;
  assign sbus3.error       = 1'b0;

  always @(posedge clk) begin
    pipe3_v    <= {pipe3_v[1:0], sbus3.read & ~sbus3.waitrequest};
    pipe3_d[0] <= mem_word(sbus3.address);
    pipe3_d[1] <= pipe3_d[0];
    pipe3_d[2] <= pipe3_d[1];
  end

  typedef struct {
    logic        s_read;
    logic        s_write;
    logic [31:0] s_address;
    logic [3:0]  s_be;
    logic [31:0] s_wdata;
    logic        i_wait;
    logic        d_wait;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
    logic        d_error;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_last_d = 1'b1;
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] m_i_hold = 32'h0;
  logic [31:0] m_d_hold = 32'h0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.s_read    = 1'b0;
    e.s_write   = 1'b0;
    e.s_address = 32'h0;
    e.s_be      = 4'b0000;
    e.s_wdata   = 32'h0;
    e.i_wait    = 1'b1;
    e.d_wait    = 1'b1;
    e.i_rdata   = m_i_hold;
    e.d_rdata   = m_d_hold;
    e.d_error   = 1'b0;
    return e;
  endfunction

  // Expands a grant into its cycles: issue (1 + stalls), read gap, then the completion cycle.
  task automatic planTransaction(inout exp_t cur);
    bit          pick_d;
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    exp_t        x;
    pick_d   = (dbus.read || dbus.write) && (!ibus.read || !m_last_d);
    m_last_d = pick_d;
    if (pick_d && dbus.read && dbus.write) begin
      cur.d_error = 1'b1;
      m_rdata     = 32'h0;
      m_d_hold    = 32'h0;
      x           = idle_exp();
      x.d_wait    = 1'b0;
      exp_q.push_back(x);
      return;
    end
    if (pick_d) begin
      addr = dbus.address; be = dbus.byteenable; wdata = dbus.writedata; is_wr = dbus.write;
    end else begin
      addr = ibus.address; be = 4'hF; wdata = 32'h0; is_wr = 1'b0;
    end
    x           = idle_exp();
    x.s_read    = !is_wr;
    x.s_write   = is_wr;
    x.s_address = addr;
    x.s_be      = be;
    x.s_wdata   = wdata;
    repeat (stall_cfg + 1) exp_q.push_back(x);
    if (!is_wr) begin
      exp_q.push_back(idle_exp());
      m_rdata = mem_word(addr);
    end
    if (pick_d) m_d_hold = m_rdata;
    else        m_i_hold = m_rdata;
    x = idle_exp();
    if (pick_d) x.d_wait = 1'b0;
    else        x.i_wait = 1'b0;
    exp_q.push_back(x);
  endtask

  task automatic compareCycle(input exp_t e);
    checkOutput("s_read",       32'(sbus.read),        32'(e.s_read));
    checkOutput("s_write",      32'(sbus.write),       32'(e.s_write));
    checkOutput("s_address",    sbus.address,          e.s_address);
    checkOutput("s_byteenable", 32'(sbus.byteenable),  32'(e.s_be));
    checkOutput("s_writedata",  sbus.writedata,        e.s_wdata);
    checkOutput("i_waitrequest", 32'(ibus.waitrequest), 32'(e.i_wait));
    checkOutput("d_waitrequest", 32'(dbus.waitrequest), 32'(e.d_wait));
    checkOutput("i_readdata",   ibus.readdata,         e.i_rdata);
    checkOutput("d_readdata",   dbus.readdata,         e.d_rdata);
    checkOutput("d_error",      32'(dbus.error),       32'(e.d_error));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_q.delete();
        m_last_d = 1'b1;
        m_rdata  = 32'h0;
        m_i_hold = 32'h0;
        m_d_hold = 32'h0;
        e = idle_exp();
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e = idle_exp();
        if (ibus.read || dbus.read || dbus.write) planTransaction(e);
      end
      compareCycle(e);
    end
  end

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                               input logic [31:0] da, input logic [3:0] dbe, input logic [31:0] dwd);
    ibus.read       = ir;
    ibus.address    = ia;
    dbus.read       = dr;
    dbus.write      = dw;
    dbus.address    = da;
    dbus.byteenable = dbe;
    dbus.writedata  = dwd;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitComplete(input bit port_d, input int max_cycles, output int cyc, output int strobes);
    cyc = -1;
    strobes = 0;
    for (int k = 0; k <= max_cycles; k++) begin
      @(negedge clk);
      if (sbus.read || sbus.write) strobes++;
      if ((port_d && !dbus.waitrequest) || (!port_d && !ibus.waitrequest)) begin
        cyc = k;
        break;
      end
    end
    if (cyc < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_timeout: port %0d no completion within %0d cycles", port_d, max_cycles);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int strobes;
    int order[$];
    int cyc3;

    reset_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    dbus3.read = 1'b0; dbus3.write = 1'b0; dbus3.address = '0;
    dbus3.byteenable = 4'h0; dbus3.writedata = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    @(negedge clk);
    checkOutput("rst_i_wait", 32'(ibus.waitrequest), 32'd1);
    checkOutput("rst_d_wait", 32'(dbus.waitrequest), 32'd1);
    checkOutput("rst_s_read", 32'(sbus.read), 32'd0);
    checkOutput("rst_i_rdata", ibus.readdata, 32'h0);

    $display("[TB] instruction fetch, no stall");
    nextCycle();
    applyStimulus(1'b1, 32'h0BFC_0000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    waitComplete(1'b0, 20, cyc, strobes);
    checkOutput("t2_latency", 32'(cyc), 32'd3);
    checkOutput("t2_strobes", 32'(strobes), 32'd1);
    checkOutput("t2_rdata", ibus.readdata, 32'h8C01_0004);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    nextCycle();

    $display("[TB] data write with two stall cycles");
    stall_cfg = 2;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    waitComplete(1'b1, 20, cyc, strobes);
    checkOutput("t3_latency", 32'(cyc), 32'd4);
    checkOutput("t3_write_cycles", 32'(strobes), 32'd3);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    stall_cfg = 0;
    nextCycle();

    $display("[TB] both ports held, grants must alternate");
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
    for (int k = 0; k < 60 && order.size() < 4; k++) begin
      @(negedge clk);
      if (!ibus.waitrequest) order.push_back(0);
      if (!dbus.waitrequest) order.push_back(1);
    end
    checkOutput("t4_count", 32'(order.size()), 32'd4);
    foreach (order[i]) checkOutput($sformatf("t4_grant%0d", i), 32'(order[i]), 32'(i % 2));
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    nextCycle();

    $display("[TB] data read and write together");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h44, 4'hF, 32'h1234_5678);
    @(negedge clk);
    checkOutput("t5_d_error", 32'(dbus.error), 32'd1);
    checkOutput("t5_no_strobe", 32'(sbus.read | sbus.write), 32'd0);
    waitComplete(1'b1, 5, cyc, strobes);
    checkOutput("t5_complete_next", 32'(cyc), 32'd0);
    checkOutput("t5_strobes", 32'(strobes), 32'd0);
    checkOutput("t5_rdata", dbus.readdata, 32'h0);
    checkOutput("t5_error_pulse", 32'(dbus.error), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    nextCycle();

    $display("[TB] reset during a stalled fetch");
    stall_cfg = 10;
    applyStimulus(1'b1, 32'h0BFC_0000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("t1_sread_before", 32'(sbus.read), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t1_sread", 32'(sbus.read), 32'd0);
    checkOutput("t1_i_wait", 32'(ibus.waitrequest), 32'd1);
    checkOutput("t1_d_wait", 32'(dbus.waitrequest), 32'd1);
    checkOutput("t1_i_rdata", ibus.readdata, 32'h0);
    checkOutput("t1_d_rdata", dbus.readdata, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    stall_cfg = 0;
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    nextCycle();
    applyStimulus(1'b1, 32'h0BFC_0000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    waitComplete(1'b0, 20, cyc, strobes);
    checkOutput("t1_recover_latency", 32'(cyc), 32'd3);
    checkOutput("t1_recover_rdata", ibus.readdata, 32'h8C01_0004);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    nextCycle();

    $display("[TB] data read with READ_LATENCY=3");
    dbus3.read = 1'b1; dbus3.address = 32'h300; dbus3.byteenable = 4'hF;
    cyc3 = -1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 4) checkOutput("t6_hold_before_capture", dbus3.readdata, 32'h0);
      if (!dbus3.waitrequest) begin
        cyc3 = k;
        break;
      end
    end
    checkOutput("t6_latency", 32'(cyc3), 32'd5);
    checkOutput("t6_rdata", dbus3.readdata, mem_word(32'h300));
    checkOutput("t6_i_wait", 32'(ibus3.waitrequest), 32'd1);
    nextCycle();
    dbus3.read = 1'b0;
    repeat (2) nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
